// File: rtl/cache_write_queue.sv
// cache_write_queue: prioritised write sources feeding a small coalescing store
// queue in front of a single cache write port, with same-cycle bypass when the
// queue is idle and a probe for pending-store hazards on loads.
module cache_write_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     CacheIndexWidth = 7,
    parameter int unsigned     CacheTagWidth   = 7,
    parameter logic [XLEN-1:0] MMIO_ADDR       = XLEN'(32'h4000_0000),
    parameter int unsigned     NUM_SRC         = 3,
    parameter int unsigned     DEPTH           = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_SRC-1:0]           i_src_valid,
    output logic [NUM_SRC-1:0]           o_src_ready,
    input  logic [NUM_SRC*XLEN-1:0]      i_src_address,
    input  logic [NUM_SRC*XLEN-1:0]      i_src_data,
    input  logic [NUM_SRC*XLEN/8-1:0]    i_src_byte_en,
    input  logic                         i_cache_port_ready,
    input  logic [CacheTagWidth-1:0]     i_cache_read_tag,
    input  logic [XLEN/8-1:0]            i_cache_read_valid,
    output logic                         o_cache_write_enable,
    output logic [XLEN/8-1:0]            o_cache_byte_write_enable,
    output logic [CacheIndexWidth-1:0]   o_cache_write_index,
    output logic [XLEN-1:0]              o_cache_write_data,
    output logic [CacheTagWidth-1:0]     o_cache_write_tag,
    output logic [XLEN/8-1:0]            o_cache_write_valid,
    input  logic [XLEN-1:0]              i_probe_address,
    output logic                         o_probe_hit,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int unsigned BW  = XLEN / 8;
    localparam int unsigned WAW = XLEN - 2;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);

    // One queued store: word address, full data word and byte enables.
    typedef struct packed {
        logic [WAW-1:0]  waddr;
        logic [XLEN-1:0] data;
        logic [BW-1:0]   be;
    } entry_t;

    // Sequential state
    logic          run_q, run_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];

    // Grant and queue-control signals
    logic               gnt_any;
    logic [NUM_SRC-1:0] gnt_oh;
    logic [XLEN-1:0]    gnt_addr;
    entry_t             gnt_entry;
    logic               q_empty;
    logic               q_full;
    logic               cacheable;
    logic               pop;
    logic               bypass;
    logic               coalesce;
    logic               push;
    logic               accept;
    logic [PW-1:0]      tail_idx;
    entry_t             tail_entry;
    entry_t             act;
    logic               unused_act;
    logic               unused_probe;

    // Fixed-priority grant: lowest-index valid source wins; nothing is granted
    // until one full cycle after reset has elapsed.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_oh    = '0;
        gnt_addr  = '0;
        gnt_entry = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (run_q && i_src_valid[s] && !gnt_any) begin
                gnt_any        = 1'b1;
                gnt_oh[s]      = 1'b1;
                gnt_addr       = i_src_address[s*XLEN +: XLEN];
                gnt_entry.data = i_src_data[s*XLEN +: XLEN];
                gnt_entry.be   = i_src_byte_en[s*BW +: BW];
            end
        end
        gnt_entry.waddr = gnt_addr[XLEN-1:2];
    end

    // Queue control: drain / bypass / coalesce / push decisions and next state.
    always_comb begin
        q_empty    = (count_q == '0);
        q_full     = (count_q == CW'(DEPTH));
        tail_idx   = tail_q - PW'(1);
        tail_entry = mem_q[tail_idx];
        cacheable  = gnt_any && (gnt_addr < MMIO_ADDR) && (gnt_entry.be != '0);
        pop        = !q_empty && i_cache_port_ready;
        bypass     = q_empty && i_cache_port_ready && cacheable;
        // The tail is unavailable for merging when it is the entry leaving now.
        coalesce   = cacheable && !q_empty
                     && !(pop && (count_q == CW'(1)))
                     && (tail_entry.waddr == gnt_entry.waddr);
        push       = cacheable && !bypass && !coalesce && (!q_full || pop);
        accept     = gnt_any && (!cacheable || bypass || coalesce || push);

        run_d   = 1'b1;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = gnt_entry;
        end
        if (coalesce) begin
            for (int b = 0; b < BW; b++) begin
                if (gnt_entry.be[b]) begin
                    mem_d[tail_idx].data[8*b +: 8] = gnt_entry.data[8*b +: 8];
                end
            end
            mem_d[tail_idx].be = tail_entry.be | gnt_entry.be;
        end
    end

    // Cache write port: the queue head has precedence, bypass only when idle.
    always_comb begin
        act                       = pop ? mem_q[head_q] : gnt_entry;
        o_cache_write_enable      = pop || bypass;
        o_cache_byte_write_enable = act.be;
        o_cache_write_index       = act.waddr[CacheIndexWidth-1:0];
        o_cache_write_tag         = act.waddr[CacheIndexWidth +: CacheTagWidth];
        o_cache_write_data        = act.data;
        o_cache_write_valid       = (i_cache_read_tag == act.waddr[CacheIndexWidth +: CacheTagWidth])
                                    ? (act.be | i_cache_read_valid) : act.be;
    end

    // Probe: any occupied slot holding the probed word address.
    always_comb begin
        o_probe_hit = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if ((CW'(PW'(PW'(e) - head_q)) < count_q) &&
                (mem_q[e].waddr == i_probe_address[XLEN-1:2])) begin
                o_probe_hit = 1'b1;
            end
        end
    end

    // Status and handshake outputs
    assign o_src_ready  = accept ? gnt_oh : '0;
    assign o_count      = count_q;
    assign o_empty      = (count_q == '0);
    assign unused_act   = ^act.waddr;
    assign unused_probe = ^i_probe_address[1:0];

    // Control state: pointers, occupancy and the post-reset run flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            run_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            run_q   <= run_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, intentionally left without reset.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_cache_write_queue.sv
// Bench for cache_write_queue: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-level reference model.
module tb_cache_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [95:0] src_addr;
    logic [95:0] src_data;
    logic [11:0] src_be;
    logic        port_ready;
    logic [6:0]  read_tag;
    logic [3:0]  read_valid;
    logic        we;
    logic [3:0]  bwe;
    logic [6:0]  widx;
    logic [31:0] wdata;
    logic [6:0]  wtag;
    logic [3:0]  wvalid;
    logic [31:0] probe;
    logic        hit;
    logic [2:0]  count;
    logic        empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_write_queue dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_src_valid               (src_valid),
        .o_src_ready               (src_ready),
        .i_src_address             (src_addr),
        .i_src_data                (src_data),
        .i_src_byte_en             (src_be),
        .i_cache_port_ready        (port_ready),
        .i_cache_read_tag          (read_tag),
        .i_cache_read_valid        (read_valid),
        .o_cache_write_enable      (we),
        .o_cache_byte_write_enable (bwe),
        .o_cache_write_index       (widx),
        .o_cache_write_data        (wdata),
        .o_cache_write_tag         (wtag),
        .o_cache_write_valid       (wvalid),
        .i_probe_address           (probe),
        .o_probe_hit               (hit),
        .o_count                   (count),
        .o_empty                   (empty)
    );

    typedef struct packed {
        logic [2:0]  valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        pr;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [6:0]  exp_idx;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;
        logic [2:0]  exp_count;
    } vec_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } ment_t;

    vec_t  vt [23];
    ment_t mq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] valid, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input logic pr,
                                input logic [2:0] er, input logic ew, input logic [6:0] ei,
                                input logic [31:0] ed, input logic [3:0] eb, input logic [2:0] ec);
        vec_t v;
        v.valid = valid; v.addr = addr; v.data = data; v.be = be; v.pr = pr;
        v.exp_ready = er; v.exp_we = ew; v.exp_idx = ei; v.exp_data = ed;
        v.exp_be = eb; v.exp_count = ec;
        return v;
    endfunction

    // Drive one cycle with all sources sharing address/data/enables, then check.
    task automatic cyc(input string name, input vec_t v);
        @(negedge clk);
        src_valid  = v.valid;
        src_addr   = {3{v.addr}};
        src_data   = {3{v.data}};
        src_be     = {3{v.be}};
        port_ready = v.pr;
        #1;
        chk($sformatf("%s.ready", name), 64'(src_ready), 64'(v.exp_ready));
        chk($sformatf("%s.we", name), 64'(we), 64'(v.exp_we));
        chk($sformatf("%s.count", name), 64'(count), 64'(v.exp_count));
        chk($sformatf("%s.empty", name), 64'(empty), 64'(v.exp_count == 3'd0));
        if (v.exp_we) begin
            chk($sformatf("%s.idx", name), 64'(widx), 64'(v.exp_idx));
            chk($sformatf("%s.data", name), 64'(wdata), 64'(v.exp_data));
            chk($sformatf("%s.be", name), 64'(bwe), 64'(v.exp_be));
            chk($sformatf("%s.valid", name), 64'(wvalid), 64'(v.exp_be));
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'h4000_0000 + 32'($urandom_range(0, 255));
        return 32'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        // Directed vectors, starting on the first cycle after reset release.
        vt[0]  = mk(3'b001, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[1]  = mk(3'b001, 32'h100, 32'hDEADBEEF, 4'hF, 1'b1, 3'b001, 1'b1, 7'h40, 32'hDEADBEEF, 4'hF, 3'd0);
        vt[2]  = mk(3'b010, 32'h4000_0000, 32'h12345678, 4'hF, 1'b1, 3'b010, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[3]  = mk(3'b001, 32'h104, 32'h11111111, 4'h1, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[4]  = mk(3'b001, 32'h104, 32'h22222222, 4'h2, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd1);
        vt[5]  = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h41, 32'h11112211, 4'h3, 3'd1);
        vt[6]  = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[7]  = mk(3'b001, 32'h300, 32'h30000000, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[8]  = mk(3'b001, 32'h304, 32'h30000004, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd1);
        vt[9]  = mk(3'b001, 32'h308, 32'h30000008, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd2);
        vt[10] = mk(3'b001, 32'h30C, 32'h3000000C, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd3);
        vt[11] = mk(3'b001, 32'h310, 32'h30000010, 4'hF, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd4);
        vt[12] = mk(3'b001, 32'h310, 32'h30000010, 4'hF, 1'b1, 3'b001, 1'b1, 7'h40, 32'h30000000, 4'hF, 3'd4);
        vt[13] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd4);
        vt[14] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h41, 32'h30000004, 4'hF, 3'd4);
        vt[15] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h42, 32'h30000008, 4'hF, 3'd3);
        vt[16] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h43, 32'h3000000C, 4'hF, 3'd2);
        vt[17] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h44, 32'h30000010, 4'hF, 3'd1);
        vt[18] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[19] = mk(3'b101, 32'h480, 32'hAAAA0000, 4'hF, 1'b1, 3'b001, 1'b1, 7'h20, 32'hAAAA0000, 4'hF, 3'd0);
        vt[20] = mk(3'b100, 32'h480, 32'hAAAA0000, 4'hF, 1'b1, 3'b100, 1'b1, 7'h20, 32'hAAAA0000, 4'hF, 3'd0);
        vt[21] = mk(3'b001, 32'h500, 32'h55555555, 4'h0, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);
        vt[22] = mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0);

        rst = 1'b1; src_valid = 3'b000; src_addr = '0; src_data = '0; src_be = '0;
        port_ready = 1'b0; read_tag = '0; read_valid = '0; probe = '0;
        repeat (2) @(posedge clk);

        // Held in reset with a live request and a ready port.
        @(negedge clk);
        src_valid = 3'b001; src_addr = {3{32'h100}}; src_be = {3{4'hF}}; port_ready = 1'b1;
        #1;
        chk("rst.ready", 64'(src_ready), 64'(0));
        chk("rst.we", 64'(we), 64'(0));
        chk("rst.count", 64'(count), 64'(0));
        chk("rst.empty", 64'(empty), 64'(1));
        chk("rst.hit", 64'(hit), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 23; i++) cyc($sformatf("vec%0d", i), vt[i]);

        // Merge must not target the entry being drained this cycle.
        cyc("nomrg_a", mk(3'b001, 32'h600, 32'h11111111, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0));
        cyc("nomrg_b", mk(3'b001, 32'h600, 32'h22222222, 4'h1, 1'b1, 3'b001, 1'b1, 7'h00, 32'h11111111, 4'hF, 3'd1));
        cyc("nomrg_c", mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 3'b000, 1'b0, 7'h00, 32'h0, 4'h0, 3'd1));
        cyc("nomrg_d", mk(3'b000, 32'h0, 32'h0, 4'h0, 1'b1, 3'b000, 1'b1, 7'h00, 32'h22222222, 4'h1, 3'd1));

        // Probe hazard detection, then asynchronous reset while an entry is queued.
        cyc("probe_push", mk(3'b001, 32'h200, 32'h5A5A5A5A, 4'hF, 1'b0, 3'b001, 1'b0, 7'h00, 32'h0, 4'h0, 3'd0));
        @(negedge clk);
        src_valid = 3'b000; port_ready = 1'b0; probe = 32'h202;
        #1;
        chk("probe.hit", 64'(hit), 64'(1));
        chk("probe.count", 64'(count), 64'(1));
        probe = 32'h204;
        #1;
        chk("probe.miss", 64'(hit), 64'(0));
        probe = 32'h202; src_valid = 3'b001; src_addr = {3{32'h200}}; src_be = {3{4'hF}};
        port_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst.count", 64'(count), 64'(0));
        chk("midrst.hit", 64'(hit), 64'(0));
        chk("midrst.empty", 64'(empty), 64'(1));
        chk("midrst.ready", 64'(src_ready), 64'(0));
        chk("midrst.we", 64'(we), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst.ready", 64'(src_ready), 64'(0));
        chk("postrst.we", 64'(we), 64'(0));
        chk("postrst.count", 64'(count), 64'(0));

        // Randomized traffic against a queue-of-stores reference model.
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  exp_ready;
            logic        exp_we;
            logic        exp_hit;
            logic        popping;
            logic        merge;
            logic        push;
            logic [31:0] ga;
            logic [6:0]  etag;
            logic [3:0]  evalid;
            ment_t       w;
            ment_t       ge;
            ment_t       t;
            int          g;

            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                src_valid[s]          = 1'($urandom_range(0, 1));
                src_addr[s*32 +: 32]  = rand_addr();
                src_data[s*32 +: 32]  = $urandom;
                src_be[s*4 +: 4]      = 4'($urandom_range(0, 15));
            end
            port_ready = ($urandom_range(0, 99) < 45);
            read_tag   = 7'($urandom_range(0, 3));
            read_valid = 4'($urandom_range(0, 15));
            probe      = rand_addr();
            #1;

            popping   = (mq.size() > 0) && port_ready;
            exp_ready = '0; exp_we = 1'b0; merge = 1'b0; push = 1'b0; w = '0; ge = '0;
            if (popping) begin
                exp_we = 1'b1;
                w      = mq[0];
            end
            g = -1;
            for (int s = 0; s < 3; s++) if (src_valid[s] && g < 0) g = s;
            if (g >= 0) begin
                ga       = src_addr[g*32 +: 32];
                ge.waddr = ga[31:2];
                ge.data  = src_data[g*32 +: 32];
                ge.be    = src_be[g*4 +: 4];
                if (ga >= 32'h4000_0000 || ge.be == 4'h0) begin
                    exp_ready[g] = 1'b1;
                end else if (mq.size() == 0 && port_ready) begin
                    exp_ready[g] = 1'b1;
                    exp_we       = 1'b1;
                    w            = ge;
                end else if (mq.size() > 0 && mq[mq.size()-1].waddr == ge.waddr &&
                             !(popping && mq.size() == 1)) begin
                    exp_ready[g] = 1'b1;
                    merge        = 1'b1;
                end else if (mq.size() < 4 || popping) begin
                    exp_ready[g] = 1'b1;
                    push         = 1'b1;
                end
            end
            exp_hit = 1'b0;
            foreach (mq[i]) if (mq[i].waddr == probe[31:2]) exp_hit = 1'b1;

            chk("rnd.ready", 64'(src_ready), 64'(exp_ready));
            chk("rnd.we", 64'(we), 64'(exp_we));
            chk("rnd.count", 64'(count), 64'(mq.size()));
            chk("rnd.empty", 64'(empty), 64'(mq.size() == 0));
            chk("rnd.hit", 64'(hit), 64'(exp_hit));
            if (exp_we) begin
                etag   = w.waddr[13:7];
                evalid = (read_tag == etag) ? (w.be | read_valid) : w.be;
                chk("rnd.idx", 64'(widx), 64'(w.waddr[6:0]));
                chk("rnd.tag", 64'(wtag), 64'(etag));
                chk("rnd.data", 64'(wdata), 64'(w.data));
                chk("rnd.be", 64'(bwe), 64'(w.be));
                chk("rnd.valid", 64'(wvalid), 64'(evalid));
            end

            if (popping) void'(mq.pop_front());
            if (merge) begin
                t = mq[mq.size()-1];
                for (int b = 0; b < 4; b++) if (ge.be[b]) t.data[8*b +: 8] = ge.data[8*b +: 8];
                t.be = t.be | ge.be;
                mq[mq.size()-1] = t;
            end
            if (push) mq.push_back(ge);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
